pwm_led_ctrl: RTL and testbench
===============================

PWM_LED_CTRL -- requirements
Module: pwm_led_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3, giving the number of PWM channels, legal range 1..8.
REQ-002 SHALL have parameter PRESC_W, default 8, giving the prescaler width in bits, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port dbw, input, 8 bits: write data bus.
REQ-006 SHALL have port addr, input, 4 bits: register address.
REQ-007 SHALL have port we, input, 1 bit: register write strobe, sampled on the clk edge.
REQ-008 SHALL have port dbr, output, 8 bits: combinational read data for addr.
REQ-009 SHALL have port pwm, output, NCH bits: PWM outputs, active-high, registered.

Function
REQ-010 Register map SHALL be:
- 0x0..NCH-1: DUTY[i] (R/W).
- 0x8: CTRL, with bit0 EN and bit1 INV.
- 0x9: PRESC, with PRESC_W low bits used.
- 0xA: FADE mask, with NCH low bits used.
- 0xB: STATUS (RO), bit0 = fade direction.
- Unmapped reads SHALL return 0x00; unmapped writes SHALL be ignored.
REQ-011 Prescaler counter SHALL count 0..PRESC and issue a one-cycle tick at PRESC, then wrap to 0; PRESC=0 SHALL give a tick every cycle.
REQ-012 8-bit period counter SHALL increment per tick and wrap 255->0; the wrap tick SHALL define the period boundary.
REQ-013 Writes to DUTY SHALL go to a shadow register.
- Shadow SHALL copy to the active duty only at the period boundary: glitch-free, no partial period.
- Readback SHALL return the shadow value.
REQ-014 Raw channel output SHALL be 1 when period counter < active duty.
- Duty 0 SHALL give constant 0.
- Duty 255 SHALL give high for 255 of 256 ticks.
REQ-015 pwm[i] SHALL be registered, giving one clk of latency from the compare.
- pwm[i] = raw XOR INV when EN=1.
- pwm[i] = INV when EN=0.
REQ-016 Fade engine SHALL be a 2-state FSM, UP/DOWN, with an 8-bit level register.
- Level SHALL step by 1 at each period boundary.
- UP at 255 -> DOWN, and level holds 255 that period.
- DOWN at 0 -> UP, and level holds 0.
REQ-017 Channels with their FADE bit set SHALL use the fade level as active duty; DUTY shadow contents SHALL be retained but unused.
REQ-018 Clearing EN SHALL:
- reset prescaler, period counter, fade level and FSM to their reset values;
- not alter register contents.
REQ-019 Setting EN SHALL restart counting from period counter 0 on the next cycle.
REQ-020 Writing PRESC SHALL take effect immediately; if the prescaler counter exceeds the new PRESC, it SHALL wrap to 0 on the next cycle.
REQ-021 A DUTY write in the same cycle as the period boundary SHALL be captured into active duty at that boundary (write wins).

Reset
REQ-022 On rst, all of the following SHALL reset asynchronously:
- DUTY shadow and active = 0x00, CTRL = 0x00, PRESC = 0, FADE = 0;
- counters = 0, fade level = 0, FSM = UP;
- pwm = all 0.
REQ-023 Reset asserted mid-period SHALL force pwm low immediately, with no wait for clk.

Structure
REQ-024 A shared package SHALL hold the register address constants (ADDR_CTRL, ADDR_PRESC, ADDR_FADE, ADDR_STATUS), the CTRL bit indices and the fade FSM state encoding.
REQ-025 Per-channel shadow/active/compare/output logic SHALL be a sub-module pwm_chan, instantiated NCH times via generate.
REQ-026 Prescaler, period counter, fade FSM and register decode SHALL reside in the top module.

Verification
REQ-027 Reset, then write CTRL=0x01, PRESC=0, DUTY0=0x40 -> from the first period boundary, pwm[0] is high 64 of every 256 clk, period 256 clk.
REQ-028 PRESC=3, DUTY1=0x80; at period counter 0x20 write DUTY1=0x10 -> current period stays at 128 ticks high (512 clk); the next period is 16 ticks high.
REQ-029 FADE=0x04, PRESC=0, EN=1 -> channel 2 duty reads 0,1,...,255,255,254,...,0,0,1 across consecutive periods; STATUS bit0 toggles at the 255 and 0 holds.
REQ-030 CTRL=0x03 with DUTY0=0x00 -> pwm[0] constant 1; then CTRL=0x02 -> pwm[0] constant 1 and counters held at 0.
REQ-031 Assert rst mid-period with pwm[0]=1 -> pwm[0]=0 before the next clk edge; all registers read 0x00.
REQ-032 Read addr 0xC..0xF -> dbr=0x00; write addr 0xE -> no register changes.

Source files
------------

// File: rtl/pwm_led_ctrl_pkg.sv
// pwm_led_ctrl_pkg: register map, CTRL bit indices and fade FSM encoding shared by the PWM LED controller.
package pwm_led_ctrl_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_PRESC  = 4'h9;
    localparam logic [3:0] ADDR_FADE   = 4'hA;
    localparam logic [3:0] ADDR_STATUS = 4'hB;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;
    typedef enum logic {
        FADE_UP   = 1'b0,
        FADE_DOWN = 1'b1
    } fade_state_t;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel with shadow/active duty, period compare and registered output.
module pwm_chan (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] dbw,
    input  logic       boundary,
    input  logic       en,
    input  logic       inv,
    input  logic       fade_sel,
    input  logic [7:0] level,
    input  logic [7:0] cnt,
    output logic [7:0] shadow,
    output logic       pwm
);
    logic [7:0] active;
    logic [7:0] duty;
    assign duty = fade_sel ? level : active;
    // a write landing on the boundary cycle goes straight into the active duty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr) shadow <= dbw;
            if (boundary) active <= wr ? dbw : shadow;
            pwm <= en ? ((cnt < duty) ^ inv) : inv;
        end
    end
endmodule

// File: rtl/pwm_led_ctrl.sv
// pwm_led_ctrl: multi-channel PWM LED controller with prescaler, 8-bit period counter,
// triangle fade engine and a small register file.
module pwm_led_ctrl
    import pwm_led_ctrl_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int PRESC_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     dbw,
    input  logic [3:0]     addr,
    input  logic           we,
    output logic [7:0]     dbr,
    output logic [NCH-1:0] pwm
);
    logic [1:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] psc;
    logic [NCH-1:0]     fade;
    logic [7:0]         cnt;
    logic [7:0]         level_q;
    logic [7:0]         level_d;
    fade_state_t        state_q;
    fade_state_t        state_d;
    logic               en;
    logic               inv;
    logic               tick;
    logic               boundary;
    logic [7:0]         shadow [NCH];

    assign en       = ctrl[CTRL_EN];
    assign inv      = ctrl[CTRL_INV];
    assign tick     = en && (psc == presc);
    assign boundary = tick && (cnt == 8'hff);

    // counters sit at zero while disabled so enabling restarts a clean period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl  <= '0;
            presc <= '0;
            fade  <= '0;
            psc   <= '0;
            cnt   <= '0;
        end else begin
            if (we && addr == ADDR_CTRL) ctrl <= dbw[1:0];
            if (we && addr == ADDR_PRESC) presc <= dbw[PRESC_W-1:0];
            if (we && addr == ADDR_FADE) fade <= dbw[NCH-1:0];
            psc <= (!en || psc >= presc) ? '0 : psc + 1'b1;
            cnt <= !en ? '0 : cnt + 8'(tick);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FADE_UP;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // the turning point holds its level for one extra period
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (!en) begin
            state_d = FADE_UP;
            level_d = '0;
        end else if (boundary) begin
            if (state_q == FADE_UP) begin
                state_d = level_q == 8'hff ? FADE_DOWN : FADE_UP;
                level_d = level_q == 8'hff ? level_q : level_q + 8'd1;
            end else begin
                state_d = level_q == 8'h00 ? FADE_UP : FADE_DOWN;
                level_d = level_q == 8'h00 ? level_q : level_q - 8'd1;
            end
        end
    end

    always_comb begin
        dbr = '0;
        for (int i = 0; i < NCH; i++)
            if (addr == 4'(i)) dbr = shadow[i];
        if (addr == ADDR_CTRL) dbr = {6'b0, ctrl};
        if (addr == ADDR_PRESC) dbr = 8'(presc);
        if (addr == ADDR_FADE) dbr = 8'(fade);
        if (addr == ADDR_STATUS) dbr = {7'b0, state_q == FADE_DOWN};
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        pwm_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr       (we && addr == 4'(c)),
            .dbw      (dbw),
            .boundary (boundary),
            .en       (en),
            .inv      (inv),
            .fade_sel (fade[c]),
            .level    (level_q),
            .cnt      (cnt),
            .shadow   (shadow[c]),
            .pwm      (pwm[c])
        );
    end
endmodule

// File: tb/tb_pwm_led_ctrl.sv
// tb_pwm_led_ctrl: directed and randomized checks of pwm_led_ctrl against a cycle-index reference model.
module tb_pwm_led_ctrl;
    localparam int NCH = 3;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           we = 1'b0;
    logic [7:0]     dbw = '0;
    logic [3:0]     addr = '0;
    logic [7:0]     dbr;
    logic [NCH-1:0] pwm;
    int total = 0;
    int bad = 0;
    // model: k = cycles since EN rose, p = PRESC; everything else derives from k by arithmetic
    int k = 0;
    int p = 0;
    logic           en_m = 1'b0;
    logic           inv_m = 1'b0;
    logic [7:0]     fade_m = '0;
    logic [7:0]     sh [NCH];
    logic [7:0]     act [NCH];
    logic [NCH-1:0] exp_pwm = '0;
    int n, h1, h2;

    pwm_led_ctrl #(.NCH(NCH), .PRESC_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .dbw  (dbw),
        .addr (addr),
        .we   (we),
        .dbr  (dbr),
        .pwm  (pwm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fade_lvl(input int m);
        int r;
        r = m % 512;
        return r < 256 ? 8'(r) : 8'(511 - r);
    endfunction

    function automatic logic [7:0] exp_reg(input logic [3:0] a);
        if (int'(a) < NCH) return sh[a];
        if (a == 4'h8) return {6'b0, inv_m, en_m};
        if (a == 4'h9) return 8'(p);
        if (a == 4'hA) return fade_m & 8'((1 << NCH) - 1);
        if (a == 4'hB) return {7'b0, ((k / (256 * (p + 1))) % 512) >= 256};
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; p = 0; en_m = 0; inv_m = 0; fade_m = '0; exp_pwm = '0;
        for (int i = 0; i < NCH; i++) begin
            sh[i] = '0;
            act[i] = '0;
        end
    endtask

    // entered just after a falling edge; checks pwm, drives one cycle, advances the model
    task automatic cyc(input logic w, input logic [3:0] a, input logic [7:0] d);
        int per, cnt, m;
        logic bnd;
        logic [7:0] du;
        chk("pwm", 32'(pwm), 32'(exp_pwm));
        we = w; addr = a; dbw = d;
        per = 256 * (p + 1);
        cnt = (k / (p + 1)) % 256;
        m = k / per;
        for (int i = 0; i < NCH; i++) begin
            du = fade_m[i] ? fade_lvl(m) : act[i];
            exp_pwm[i] = en_m ? ((cnt < int'(du)) ^ inv_m) : inv_m;
        end
        bnd = en_m && (k % per == per - 1);
        k = en_m ? k + 1 : 0;
        if (w) begin
            if (int'(a) < NCH) sh[a] = d;
            else if (a == 4'h8) begin
                en_m = d[0]; inv_m = d[1];
                if (!d[0]) k = 0;
            end else if (a == 4'h9) p = int'(d);
            else if (a == 4'hA) fade_m = d;
        end
        if (bnd) for (int i = 0; i < NCH; i++) act[i] = sh[i];
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        addr = a; we = 1'b0;
        #1;
        chk(tag, 32'(dbr), 32'(exp_reg(a)));
    endtask

    task automatic rd_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), tag);
            cyc(1'b0, 4'(a), 8'h00);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("reset_pwm", 32'(pwm), 0);
        rd_all("reset_reg");
        rst = 1'b0;
        // unmapped writes and reads
        cyc(1'b1, 4'hE, 8'($urandom_range(1, 255)));
        cyc(1'b1, 4'h5, 8'hA5);
        cyc(1'b1, 4'hF, 8'hFF);
        rd_all("unmapped");
        // basic 64/256 duty
        cyc(1'b1, 4'h8, 8'h01);
        cyc(1'b1, 4'h9, 8'h00);
        cyc(1'b1, 4'h0, 8'h40);
        repeat (260) cyc(1'b0, 4'h0, 8'h00);
        h1 = 0;
        repeat (256) begin
            h1 += int'(pwm[0]);
            cyc(1'b0, 4'h0, 8'h00);
        end
        chk("duty40_highs", 32'(h1), 64);
        // shadow update mid-period with PRESC=3
        cyc(1'b1, 4'h8, 8'h00);
        cyc(1'b1, 4'h9, 8'h03);
        cyc(1'b1, 4'h1, 8'h80);
        cyc(1'b1, 4'h8, 8'h01);
        h1 = 0; h2 = 0;
        while (k < 3100) begin
            if (k >= 1025 && k <= 2048) h1 += int'(pwm[1]);
            if (k >= 2049 && k <= 3072) h2 += int'(pwm[1]);
            cyc(k == 1152, 4'h1, 8'h10);
        end
        chk("cur_period_highs", 32'(h1), 512);
        chk("next_period_highs", 32'(h2), 64);
        rd(4'h1, "duty1_rb");
        // randomized configurations with sporadic duty writes
        for (int r = 0; r < 5; r++) begin
            cyc(1'b1, 4'h8, 8'h00);
            cyc(1'b1, 4'h9, 8'($urandom_range(0, 1)));
            for (int c = 0; c < NCH; c++) cyc(1'b1, 4'(c), 8'($urandom));
            cyc(1'b1, 4'hA, 8'($urandom));
            cyc(1'b1, 4'h8, {6'b0, 1'($urandom), 1'b1});
            n = 2 * 256 * (p + 1) + int'($urandom_range(0, 200));
            repeat (n) begin
                if ($urandom_range(0, 63) == 0) cyc(1'b1, 4'($urandom_range(0, NCH - 1)), 8'($urandom));
                else cyc(1'b0, 4'h0, 8'h00);
                if ($urandom_range(0, 31) == 0) rd(4'($urandom_range(0, 11)), "rand_rd");
            end
        end
        // inversion with duty 0, then disabled-but-inverted
        cyc(1'b1, 4'h8, 8'h00);
        cyc(1'b1, 4'hA, 8'h00);
        cyc(1'b1, 4'h9, 8'h00);
        cyc(1'b1, 4'h0, 8'h00);
        cyc(1'b1, 4'h8, 8'h03);
        repeat (300) cyc(1'b0, 4'h0, 8'h00);
        chk("inv_pwm0", 32'(pwm[0]), 1);
        cyc(1'b1, 4'h8, 8'h02);
        repeat (300) cyc(1'b0, 4'h0, 8'h00);
        chk("dis_inv_pwm0", 32'(pwm[0]), 1);
        rd(4'hB, "dis_status");
        rd(4'h8, "ctrl_rb");
        cyc(1'b1, 4'h8, 8'h01);
        repeat (300) cyc(1'b0, 4'h0, 8'h00);
        // fade on channel 2 across the 255 turnaround
        cyc(1'b1, 4'h8, 8'h00);
        cyc(1'b1, 4'hA, 8'h04);
        cyc(1'b1, 4'h8, 8'h01);
        for (int per = 0; per < 258; per++) begin
            rd(4'hB, "status");
            repeat (256) cyc(1'b0, 4'h0, 8'h00);
        end
        rd(4'hA, "fade_rb");
        // asynchronous reset while pwm[0] is high
        cyc(1'b1, 4'h8, 8'h00);
        cyc(1'b1, 4'hA, 8'h00);
        cyc(1'b1, 4'h0, 8'hFF);
        cyc(1'b1, 4'h8, 8'h01);
        repeat (266) cyc(1'b0, 4'h0, 8'h00);
        chk("pre_rst_pwm0", 32'(pwm[0]), 1);
        #1 rst = 1'b1;
        #1 chk("async_rst_pwm", 32'(pwm), 0);
        model_reset();
        @(negedge clk);
        rd_all("post_rst_reg");
        rst = 1'b0;
        cyc(1'b0, 4'h0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
